// File: rtl/clock_run_timer.sv
// Run-time limiter in front of the core clock tree: passes the clock through and,
// in timed mode, lets exactly LIMIT pulses out before holding the gated clock low.
module clock_run_timer #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned RUN_SECONDS = 10,
  localparam int unsigned LIMIT = CLK_FREQ_HZ * RUN_SECONDS,
  localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             ctrl,
  output logic             clock_ctrl,
  output logic             running,
  output logic             expired,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LimitC = CNT_W'(LIMIT);

  // Initialisers mirror the reset state so the clock passes before the first reset.
  logic [CNT_W-1:0] count_q = '0;
  logic [CNT_W-1:0] count_d;
  logic             expired_q = 1'b0;
  logic             expired_d;
  logic             running_q = 1'b0;
  logic             running_d;
  logic             gateEn_q = 1'b1;

  // Leaving timed mode abandons the window; in timed mode the count saturates at LIMIT.
  always_comb begin
    count_d   = '0;
    expired_d = 1'b0;
    running_d = 1'b0;
    if (ctrl) begin
      count_d = count_q;
      if (count_q < LimitC) begin
        count_d = count_q + CNT_W'(1);
      end
      expired_d = (count_d == LimitC);
      running_d = ~expired_d;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      count_q   <= '0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
      running_q <= running_d;
    end
  end

  // The enable only moves while clock is low, so a gated pulse is never truncated.
  always_ff @(negedge clock) begin
    gateEn_q <= ~expired_q;
  end

  assign clock_ctrl = clock & gateEn_q;
  assign running    = running_q;
  assign expired    = expired_q;
  assign count      = count_q;

endmodule

// File: tb/tb_clock_run_timer.sv
// Directed bench for clock_run_timer: a small LIMIT=8 instance checked every cycle
// against a run-length model, plus a default-size instance for the saturation edge.
module tb_clock_run_timer;

  localparam int Lim = 8;
  localparam logic [28:0] BigLimit = 29'd500000000;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        ctrl  = 1'b0;
  logic        clockCtrl;
  logic        running;
  logic        expired;
  logic [3:0]  count;
  logic        clockCtrlBig;
  logic        runningBig;
  logic        expiredBig;
  logic [28:0] countBig;

  int numChecks = 0;
  int numBad    = 0;
  int pulseCnt  = 0;
  int pulseBig  = 0;
  int runLen    = 0;
  bit prevExp   = 1'b0;

  clock_run_timer #(.CLK_FREQ_HZ(4), .RUN_SECONDS(2)) dut (
    .clock      (clock),
    .rst        (rst),
    .ctrl       (ctrl),
    .clock_ctrl (clockCtrl),
    .running    (running),
    .expired    (expired),
    .count      (count)
  );

  clock_run_timer dutBig (
    .clock      (clock),
    .rst        (rst),
    .ctrl       (ctrl),
    .clock_ctrl (clockCtrlBig),
    .running    (runningBig),
    .expired    (expiredBig),
    .count      (countBig)
  );

  always #5 clock = ~clock;

  always @(posedge clockCtrl) pulseCnt++;
  always @(posedge clockCtrlBig) pulseBig++;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    numChecks++;
    if (act !== exp) begin
      numBad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive rst/ctrl from a falling edge and hold them for n rising edges.
  task automatic applyStimulus(input logic r, input logic c, input int n);
    rst  = r;
    ctrl = c;
    repeat (n) @(negedge clock);
  endtask

  // Model: the window is just the number of consecutive timed edges since the last
  // reset or free-run edge; a high phase passes unless the window was used up before it.
  always begin
    @(posedge clock);
    prevExp = (runLen >= Lim);
    if (rst || !ctrl) runLen = 0;
    else if (runLen < Lim) runLen++;
    #1;
    checkOutput("count", count, (runLen < Lim) ? runLen : Lim);
    checkOutput("expired", expired, runLen >= Lim);
    checkOutput("running", running, runLen > 0 && runLen < Lim);
    checkOutput("clock_ctrl_high", clockCtrl, !prevExp);
    @(negedge clock);
    #1;
    checkOutput("clock_ctrl_low", clockCtrl, 0);
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 2);

    // Free-run: every pulse passes.
    pulseCnt = 0;
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("t1_pulses", pulseCnt, 20);
    checkOutput("t1_count", count, 0);
    checkOutput("t1_expired", expired, 0);

    // Timed run: exactly 8 pulses, then held low.
    pulseCnt = 0;
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("t2_pulses", pulseCnt, 8);
    checkOutput("t2_count", count, 8);
    checkOutput("t2_expired", expired, 1);
    checkOutput("t2_running", running, 0);

    // Drop ctrl after expiry, then a fresh window.
    pulseCnt = 0;
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("t3_count_clr", count, 0);
    checkOutput("t3_expired_clr", expired, 0);
    checkOutput("t3_gap_pulses", pulseCnt, 0);
    pulseCnt = 0;
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("t3_pulses", pulseCnt, 8);
    checkOutput("t3_expired", expired, 1);

    // Reset after P5 restores a full window.
    applyStimulus(1'b0, 1'b0, 1);
    pulseCnt = 0;
    applyStimulus(1'b0, 1'b1, 5);
    checkOutput("t4_count5", count, 5);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("t4_count_rst", count, 0);
    checkOutput("t4_expired_rst", expired, 0);
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("t4_pulses", pulseCnt, 14);

    // rst and ctrl together: rst wins and the clock still passes.
    applyStimulus(1'b0, 1'b0, 1);
    pulseCnt = 0;
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("t5_rst_pulses", pulseCnt, 3);
    checkOutput("t5_rst_count", count, 0);
    checkOutput("t5_rst_running", running, 0);
    pulseCnt = 0;
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("t5_first_count", count, 1);
    checkOutput("t5_first_running", running, 1);
    applyStimulus(1'b0, 1'b1, 9);
    checkOutput("t5_sat_count", count, 8);
    checkOutput("t5_pulses", pulseCnt, 8);

    // Default-size instance: jump to LIMIT-1 and cross the boundary.
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("t6_big_count3", countBig, 3);
    force dutBig.count_q = BigLimit - 29'd1;
    #1;
    release dutBig.count_q;
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("t6_big_count", countBig, 500000000);
    checkOutput("t6_big_expired", expiredBig, 1);
    checkOutput("t6_big_running", runningBig, 0);
    pulseBig = 0;
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("t6_big_pulses", pulseBig, 0);
    checkOutput("t6_big_nowrap", countBig, 500000000);

    $display("test done: total=%0d bad=%0d", numChecks, numBad);
    $finish;
  end

endmodule
